// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NREQ valid/ready requesters, with bounded bursts.
// Optional per-requester beat counters (stat_clr / stat_beats) are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*WIDTH-1:0]      req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_din,
  output logic [$clog2(NREQ)-1:0]    gnt_id,
  output logic                       busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [NREQ*16-1:0]         stat_beats
`endif
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t         state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] last;
  logic [IDW-1:0] pick;
  logic [3:0]     beats;
  logic           owner_valid;
  logic           accept;

  // Walk downward so the closest valid index after last overwrites farther ones.
  always_comb begin
    pick = last;
    for (int i = NREQ; i >= 1; i--) begin
      if (req_valid[(int'(last) + i) % NREQ]) pick = IDW'((int'(last) + i) % NREQ);
    end
  end

  assign owner_valid = req_valid[owner];
  assign accept      = (state == S_GRANT) && owner_valid && !fifo_full;
  assign fifo_wr_en  = accept;
  assign busy        = (state == S_GRANT);
  assign gnt_id      = owner;
  assign fifo_din    = (state == S_GRANT) ? req_data[int'(owner)*WIDTH +: WIDTH] : '0;

  always_comb begin
    req_ready = '0;
    if (state == S_GRANT && !fifo_full) req_ready[owner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      owner <= '0;
      last  <= IDW'(NREQ - 1);
      beats <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            owner <= pick;
            beats <= '0;
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          // Release on a completed burst or when the owner withdraws.
          if (!owner_valid || (accept && beats == 4'(BURST - 1))) begin
            state <= S_IDLE;
            last  <= owner;
          end else if (accept) begin
            beats <= beats + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
    logic [15:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (stat_clr) begin
        cnt <= '0;
      end else if (accept && owner == IDW'(gi) && cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
    end
    assign stat_beats[gi*16 +: 16] = cnt;
  end
`endif

endmodule
